// File: rtl/stdout_uart.sv
// stdout_uart: captures bytes strobed out of the brainfuck core, buffers
// them in a small circular FIFO and transmits each one as an 8N1 UART frame.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   reset     synchronous, active-high
//   stdout    byte from the core, valid while stdout_en is high
//   stdout_en write strobe, one byte per high cycle
//   tx        UART line, idles high
//   full      FIFO holds FIFO_DEPTH entries (registered)
//   idle      FIFO empty and transmitter idle (registered)
//   overflow  sticky, a byte was dropped; cleared only by reset
module stdout_uart #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] stdout,
  input  logic       stdout_en,
  output logic       tx,
  output logic       full,
  output logic       idle,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_n;

  state_t        state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n;
  logic          load;
  logic          push;

  // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
  assign push = stdout_en && ((count < DEPTH_C) || load);

  always_comb begin
    unique case ({push, load})
      2'b10:   count_n = count + CNT_ONE;
      2'b01:   count_n = count - CNT_ONE;
      default: count_n = count;
    endcase
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (count != '0) begin
          load    = 1'b1;
          shreg_n = mem[rd_ptr];
          tx_n    = 1'b0;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_n    = '0;
          tx_n      = shreg[0];
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_idx != 3'd7) begin
            shreg_n   = shreg >> 1;
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shreg[1];
          end else begin
            tx_n    = 1'b1;
            state_n = STOP;
          end
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          // Reload straight from the stop bit so buffered bytes leave with no gap.
          if (count != '0) begin
            load    = 1'b1;
            shreg_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + BAUD_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stdout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      full     <= 1'b0;
      idle     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (load) rd_ptr <= rd_ptr + PTR_ONE;
      if (stdout_en && !push) overflow <= 1'b1;
      count   <= count_n;
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
      full    <= (count_n == DEPTH_C);
      idle    <= (count_n == '0) && (state_n == IDLE);
    end
  end

endmodule

// File: doc/stdout_uart.md
# stdout_uart

Output stage that sits directly downstream of the brainfuck processor core. It captures each byte presented on the core's `stdout`/`stdout_en` pulse, buffers it in a small FIFO, and serialises it as 8N1 UART on a single `tx` pin. A registered `full` flag is provided so the top level can hold the core's `en` low instead of losing characters.

## Interface
- `CLKS_PER_BIT`, default 104, clock cycles per UART bit; must be at least 2.
- `FIFO_DEPTH`, default 8, number of FIFO entries; must be a power of two and at least 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stdout`  in  8  byte from the core; valid only while `stdout_en` is high.
- `stdout_en`  in  1  write strobe; each high cycle is one byte.
- `tx`  out  1  UART line; idles high.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `idle`  out  1  FIFO is empty and the transmitter is in IDLE.
- `overflow`  out  1  sticky; a byte was dropped. Cleared only by `reset`.

## Operation
- **Reset values:** `tx`=1, `full`=0, `idle`=1, `overflow`=0. FIFO pointers and count are 0. State is IDLE. Baud and bit counters are 0.
- **FIFO storage:** circular buffer.
  - Read and write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally.
  - The count is `$clog2(FIFO_DEPTH)+1` bits wide.
- **Push:** when `stdout_en`=1, the byte is written if count < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - If neither holds, the byte is discarded and `overflow` is set to 1.
- **Pop:** occurs only on a transmitter load event (see the state machine below).
  - The head byte moves into the 8-bit shift register.
  - The read pointer advances.
- **Simultaneous push and pop:** the count is unchanged. This holds for the empty case too: a push into an empty FIFO cannot pop in the same cycle, because the head is not yet valid.
- **Output flags:** `full` and `idle` are registered from the next-state count and state. They are therefore exact in the cycle after each edge.
- **Transmitter states:** IDLE, START, DATA, STOP. `tx` is driven from a register.
  - **IDLE:** `tx`=1. If count > 0: load event, `tx`<=0, baud counter <=0, go to START.
  - **START:** hold `tx`=0 for `CLKS_PER_BIT` cycles. At baud counter = `CLKS_PER_BIT`-1: counter <=0, `tx`<=bit0, bit index <=0, go to DATA.
  - **DATA:** each bit is held `CLKS_PER_BIT` cycles, LSB first.
    - At the end of a bit with index < 7: shift, index +1, `tx`<=next bit.
    - At the end of bit 7: `tx`<=1, go to STOP.
  - **STOP:** hold `tx`=1 for `CLKS_PER_BIT` cycles. At the end of the stop bit:
    - if count > 0: load event, `tx`<=0, go to START (back-to-back, no extra idle cycle);
    - otherwise go to IDLE.
- **Reset during a frame:** the frame is aborted. `tx` returns to 1 on the following cycle and all buffered bytes are discarded. No partial-frame recovery is provided.

## Timing
- **Push latency:** `stdout_en` sampled at edge E0 means the byte is in the FIFO after E0.
- **Start latency:** from the IDLE state, the load happens at E1 and `tx` goes low after E1. That is 2 edges from the strobe to the start bit.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles. Consecutive buffered bytes have zero gap.
- **Strobe rate:** one byte per cycle is accepted while space remains. The core's strobe is a single-cycle pulse at most once per 4 cycles.
- **Assertion of `full`:** `full` rises in the cycle after the push that fills the FIFO.
  - The upstream core must see `full` one cycle before its next possible strobe to avoid drops.
  - The core's 4-cycle spacing guarantees this.

## Test plan
- **Reset state:** hold `reset` 2 cycles, then release -> `tx`=1, `idle`=1, `full`=0, `overflow`=0. `tx` stays 1 for 100 cycles with no strobe.
- **Single byte:** `CLKS_PER_BIT`=4, one strobe with `stdout`=0x41 at E0 -> `tx` low from E1.
  - Bit pattern is 0,1,0,0,0,0,0,1,0,1, each held 4 cycles. That is 40 cycles total.
  - Afterwards `idle`=1.
- **Back-to-back:** `CLKS_PER_BIT`=4, three strobes 0x55, 0x00, 0xFF spaced 4 cycles apart -> three contiguous 40-cycle frames with no high gap between the stop and next start bits. `idle` rises exactly after cycle 120 of transmission.
- **Overflow:** `FIFO_DEPTH`=4, 6 strobes on consecutive cycles with bytes 0x10..0x15.
  - 0x10 is popped at E1 and 0x11–0x14 fill the FIFO, so `full`=1 after E4.
  - 0x15 is dropped and `overflow`=1.
  - Output is 5 frames, 0x10..0x14. `overflow` stays 1 until reset.
- **Simultaneous push/pop at full:** `FIFO_DEPTH`=4 with the FIFO full, strobe exactly on the stop-bit end edge -> byte accepted, count stays 4, `overflow` stays 0.
- **Reset mid-frame:** assert `reset` during DATA bit 3 with 2 bytes buffered -> `tx`=1 the next cycle, `idle`=1, no further frames emitted.
